// File: rtl/pvt_pkg.sv
// Shared types and helpers for the PVT ring-oscillator scanner.
package pvt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_GATE,
      ST_STORE,
      ST_DONE
   } state_t;

   localparam int SETTLE_CYCLES = 2;

   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pvt_sync.sv
// Single-bit multi-flop synchroniser with synchronous active-high reset.
module pvt_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], d};
   end

   assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pvt_osc_scanner.sv
// Round-robin ring-oscillator frequency scanner with per-channel result bank.
// Optional threshold alarms are enabled by defining PVT_ALARM_EN.
module pvt_osc_scanner
   import pvt_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int GATE_LOG2   = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH-1:0]           osc_in,
   input  logic                        start,
   input  logic                        continuous,
   output logic                        busy,
   output logic                        done,
   output logic [sel_w(NUM_CH)-1:0]    cur_ch,
   input  logic [sel_w(NUM_CH)-1:0]    rd_ch,
   output logic [CNT_W-1:0]            rd_data,
   output logic [NUM_CH-1:0]           rd_valid,
`ifdef PVT_ALARM_EN
   input  logic [CNT_W-1:0]            thr_lo,
   input  logic [CNT_W-1:0]            thr_hi,
   input  logic                        alarm_clr,
   output logic [NUM_CH-1:0]           alarm,
`endif
   output logic [NUM_CH-1:0]           ovf
);

   localparam int SEL_W = sel_w(NUM_CH);
   localparam int TW    = (GATE_LOG2 > 1) ? GATE_LOG2 : 2;
   localparam logic [TW-1:0]    GATE_LAST   = TW'(2**GATE_LOG2 - 1);
   localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t             r_state, w_state_nxt;
   logic [TW-1:0]      r_timer;
   logic [SEL_W-1:0]   r_cur_ch;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_lovf;
   logic               r_prev;
   logic [NUM_CH-1:0]  w_synced_all;
   logic               w_synced;
   logic               w_last;
   logic [CNT_W-1:0]   r_result [NUM_CH];
   logic [NUM_CH-1:0]  r_valid;
   logic [NUM_CH-1:0]  r_ovf;
   logic [CNT_W-1:0]   w_rd_data;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
      pvt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk (clk),
         .rst (rst),
         .d   (osc_in[g]),
         .q   (w_synced_all[g])
      );
   end

   always_comb begin
      w_synced = 1'b0;
      for (int i = 0; i < NUM_CH; i++)
         if (r_cur_ch == SEL_W'(i)) w_synced = w_synced_all[i];
   end

   assign w_last = (r_cur_ch == SEL_W'(NUM_CH - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_state_nxt = ST_SETTLE;
         ST_SETTLE: if (r_timer == SETTLE_LAST) w_state_nxt = ST_GATE;
         ST_GATE:   if (r_timer == GATE_LAST) w_state_nxt = ST_STORE;
         ST_STORE:  w_state_nxt = w_last ? ST_DONE : ST_SETTLE;
         ST_DONE:   w_state_nxt = continuous ? ST_SETTLE : ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Timer restarts on every state change, so SETTLE and GATE each count from 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_timer  <= '0;
         r_cur_ch <= '0;
         r_prev   <= 1'b0;
         r_cnt    <= '0;
         r_lovf   <= 1'b0;
      end else begin
         r_timer <= (w_state_nxt != r_state) ? '0 : r_timer + 1'b1;
         r_prev  <= w_synced;
         if ((r_state == ST_IDLE && start) || (r_state == ST_DONE && continuous))
            r_cur_ch <= '0;
         else if (r_state == ST_STORE && !w_last)
            r_cur_ch <= r_cur_ch + 1'b1;
         if (r_state == ST_SETTLE) begin
            r_cnt  <= '0;
            r_lovf <= 1'b0;
         end else if (r_state == ST_GATE && w_synced && !r_prev) begin
            if (r_cnt == CNT_MAX) r_lovf <= 1'b1;
            else                  r_cnt  <= r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_ovf   <= '0;
         for (int i = 0; i < NUM_CH; i++) r_result[i] <= '0;
      end else if (r_state == ST_STORE) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (r_cur_ch == SEL_W'(i)) begin
               r_result[i] <= r_cnt;
               r_valid[i]  <= 1'b1;
               r_ovf[i]    <= r_lovf;
            end
         end
      end
   end

`ifdef PVT_ALARM_EN
   logic [NUM_CH-1:0] r_alarm;
   logic              w_viol;

   assign w_viol = (r_cnt < thr_lo) || (r_cnt > thr_hi) || r_lovf;

   // A violation stored in the same cycle as alarm_clr keeps its bit set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alarm <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (r_state == ST_STORE && r_cur_ch == SEL_W'(i) && w_viol)
               r_alarm[i] <= 1'b1;
            else if (alarm_clr)
               r_alarm[i] <= 1'b0;
         end
      end
   end

   assign alarm = r_alarm;
`endif

   always_comb begin
      w_rd_data = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (rd_ch == SEL_W'(i)) w_rd_data = r_result[i];
   end

   assign rd_data  = w_rd_data;
   assign rd_valid = r_valid;
   assign ovf      = r_ovf;
   assign cur_ch   = r_cur_ch;
   assign busy     = (r_state != ST_IDLE);
   assign done     = (r_state == ST_DONE);

endmodule
